// File: rtl/bch_15_7_pkg.sv
// Shared constants and FSM state type for the serial BCH(15,7) encoder.
package bch_15_7_pkg;

  localparam int unsigned N       = 15;
  localparam int unsigned K       = 7;
  localparam int unsigned PAR_LEN = 8;

  // Low coefficients of g(x) = x^8 + x^7 + x^6 + x^4 + 1; x^8 is implicit.
  localparam logic [PAR_LEN-1:0] GEN_POLY_DEFAULT = 8'hD1;

  typedef enum logic [1:0] {
    IDLE,
    MSG,
    PAR
  } state_e;

endpackage

// File: rtl/bch_lfsr_div.sv
// Serial polynomial divider: accumulates the remainder of m(x)*x^8 mod g(x),
// then shifts the remainder out MSB first with zero fill.
module bch_lfsr_div
  import bch_15_7_pkg::*;
#(
  parameter logic [PAR_LEN-1:0] Poly = GEN_POLY_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               shift_i,
  input  logic               feed_en_i,
  input  logic               bit_in_i,
  output logic [PAR_LEN-1:0] remainder_o
);

  logic [PAR_LEN-1:0] r_q, r_d;
  logic [PAR_LEN-1:0] base;
  logic               fb;

  always_comb begin
    // Clearing and feeding in the same cycle lets the first message bit load directly.
    base = clr_i ? '0 : r_q;
    fb   = feed_en_i & (bit_in_i ^ base[PAR_LEN-1]);
    r_d  = base;
    if (shift_i) begin
      r_d = {base[PAR_LEN-2:0], 1'b0} ^ (fb ? Poly : '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  assign remainder_o = r_q;

endmodule

// File: rtl/bch_15_7_serial_enc.sv
// Serial systematic BCH(15,7) encoder: 7 message bits then 8 parity bits.
// Define BCH_ENC_PAR_OUT_EN to also get a parallel codeword (cw_out/cw_valid).
module bch_15_7_serial_enc
  import bch_15_7_pkg::*;
#(
  parameter logic [PAR_LEN-1:0] GEN_POLY = GEN_POLY_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         din,
  output logic         out_bit,
  output logic         out_valid,
  output logic         out_last,
  output logic         busy
`ifdef BCH_ENC_PAR_OUT_EN
  ,
  output logic [N-1:0] cw_out,
  output logic         cw_valid
`endif
);

  localparam logic [3:0] LastMsgCnt = 4'(K - 1);
  localparam logic [3:0] LastCnt    = 4'(N - 1);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               lfsr_clr, lfsr_shift, lfsr_feed;
  logic [PAR_LEN-1:0] rem;
  logic               out_bit_d, out_valid_d, out_last_d;

  bch_lfsr_div #(
    .Poly (GEN_POLY)
  ) u_lfsr_div (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (lfsr_clr),
    .shift_i     (lfsr_shift),
    .feed_en_i   (lfsr_feed),
    .bit_in_i    (din),
    .remainder_o (rem)
  );

  // cnt_q equals the cycle index within an encode; the start cycle is 0.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lfsr_clr    = 1'b0;
    lfsr_shift  = 1'b0;
    lfsr_feed   = 1'b0;
    out_bit_d   = 1'b0;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d     = MSG;
          cnt_d       = 4'd1;
          lfsr_clr    = 1'b1;
          lfsr_shift  = 1'b1;
          lfsr_feed   = 1'b1;
          out_bit_d   = din;
          out_valid_d = 1'b1;
        end
      end
      MSG: begin
        lfsr_shift  = 1'b1;
        lfsr_feed   = 1'b1;
        out_bit_d   = din;
        out_valid_d = 1'b1;
        cnt_d       = cnt_q + 4'd1;
        if (cnt_q == LastMsgCnt) begin
          state_d = PAR;
        end
      end
      PAR: begin
        lfsr_shift  = 1'b1;
        out_bit_d   = rem[PAR_LEN-1];
        out_valid_d = 1'b1;
        cnt_d       = cnt_q + 4'd1;
        if (cnt_q == LastCnt) begin
          // Back in IDLE while c0 is presented, so a start here runs back-to-back.
          out_last_d = 1'b1;
          state_d    = IDLE;
          cnt_d      = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_bit   <= out_bit_d;
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
    end
  end

  assign busy = (state_q != IDLE);

`ifdef BCH_ENC_PAR_OUT_EN
  // Collects c14..c1; the final bit joins directly when cw_out is loaded.
  logic [N-2:0] cw_sr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cw_sr_q  <= '0;
      cw_out   <= '0;
      cw_valid <= 1'b0;
    end else begin
      cw_valid <= out_last_d;
      if (out_valid_d) begin
        cw_sr_q <= {cw_sr_q[N-3:0], out_bit_d};
      end
      if (out_last_d) begin
        cw_out <= {cw_sr_q, out_bit_d};
      end
    end
  end
`endif

endmodule

// File: tb/tb_bch_15_7_serial_enc.sv
// Directed scoreboard bench for the serial BCH(15,7) encoder.
module tb_bch_15_7_serial_enc;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        din;
  logic        out_bit, out_valid, out_last, busy;
`ifdef BCH_ENC_PAR_OUT_EN
  logic [14:0] cw_out;
  logic        cw_valid;
  logic [14:0] exp_cw = '0;
`endif

  always #5 clk = ~clk;

  bch_15_7_serial_enc dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din       (din),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .out_last  (out_last),
`ifdef BCH_ENC_PAR_OUT_EN
    .cw_out    (cw_out),
    .cw_valid  (cw_valid),
`endif
    .busy      (busy)
  );

  typedef struct packed {
    logic        b;
    logic        last;
    logic [14:0] cw;
  } exp_t;

  exp_t        exp_q[$];
  logic        din_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_last   = 0;
  logic [14:0] got_cw   = '0;

  // Remainder of m(x)*x^8 by long division with g(x) = 0x1D1.
  function automatic logic [7:0] parity_of(input logic [6:0] m);
    logic [14:0] w;
    logic [14:0] g;
    w = {m, 8'h00};
    g = 15'h01D1;
    for (int i = 14; i >= 8; i--) begin
      if (w[i]) w = w ^ (g << (i - 8));
    end
    return w[7:0];
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic chk15(input string tag, input logic [14:0] obs, input logic [14:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    logic ev;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      ev = 1'b1;
    end else begin
      e  = '0;
      ev = 1'b0;
    end
    chk1("out_valid", out_valid, ev);
    chk1("out_bit", out_bit, e.b);
    chk1("out_last", out_last, e.last);
    chk1("busy", busy, logic'(exp_q.size() != 0));
    if (out_valid) got_cw = {got_cw[13:0], out_bit};
    if (out_last) n_last++;
`ifdef BCH_ENC_PAR_OUT_EN
    if (ev && e.last) exp_cw = e.cw;
    chk1("cw_valid", cw_valid, ev & e.last);
    chk15("cw_out", cw_out, exp_cw);
`endif
  endtask

  // One clock cycle: drive inputs, advance past the edge, check the scoreboard.
  task automatic cyc(input logic st, input logic [6:0] m);
    logic [14:0] cw;
    if (st && exp_q.size() == 0 && din_q.size() == 0) begin
      cw = {m, parity_of(m)};
      for (int i = 14; i >= 0; i--) exp_q.push_back('{b: cw[i], last: (i == 0), cw: cw});
      for (int i = 6; i >= 0; i--) din_q.push_back(m[i]);
    end
    start = st;
    din   = (din_q.size() != 0) ? din_q.pop_front() : 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    start = 1'b0;
    check_outputs();
  endtask

  task automatic encode(input logic [6:0] m);
    cyc(1'b1, m);
    repeat (14) cyc(1'b0, 7'h00);
  endtask

  task automatic check_all_zero(input string tag);
    chk1({tag, "_out_bit"}, out_bit, 1'b0);
    chk1({tag, "_out_valid"}, out_valid, 1'b0);
    chk1({tag, "_out_last"}, out_last, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
`ifdef BCH_ENC_PAR_OUT_EN
    chk15({tag, "_cw_out"}, cw_out, 15'h0000);
    chk1({tag, "_cw_valid"}, cw_valid, 1'b0);
`endif
  endtask

  initial begin
    int          lasts_before;
    logic [6:0]  m;
    reset = 1'b0;
    start = 1'b0;
    din   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    repeat (2) cyc(1'b0, 7'h00);

    // All-zero message
    encode(7'h00);
    chk15("cw_zero", got_cw, 15'h0000);
    repeat (2) cyc(1'b0, 7'h00);

    // Single low-order message bit exposes the generator itself
    encode(7'h01);
    chk15("cw_one", got_cw, 15'b000000111010001);
    repeat (2) cyc(1'b0, 7'h00);

    // All-ones message
    encode(7'h7F);
    chk15("cw_ones", got_cw, 15'h7FFF);
    repeat (3) cyc(1'b0, 7'h00);

    // Back-to-back encodes, second start in cycle 15 of the first
    lasts_before = n_last;
    encode(7'h55);
    chk15("cw_b2b_a", got_cw, {7'h55, parity_of(7'h55)});
    encode(7'h2A);
    chk15("cw_b2b_b", got_cw, {7'h2A, parity_of(7'h2A)});
    chk15("b2b_last_count", 15'(n_last - lasts_before), 15'd2);
    repeat (2) cyc(1'b0, 7'h00);

    // Start re-asserted in cycle 5 must be ignored
    cyc(1'b1, 7'h4B);
    repeat (4) cyc(1'b0, 7'h00);
    cyc(1'b1, 7'h00);
    repeat (9) cyc(1'b0, 7'h00);
    chk15("cw_restart_ignored", got_cw, {7'h4B, parity_of(7'h4B)});
    repeat (2) cyc(1'b0, 7'h00);

    // Reset asserted in cycle 9 of an encode
    cyc(1'b1, 7'h33);
    repeat (8) cyc(1'b0, 7'h00);
    reset = 1'b0;
    exp_q.delete();
    din_q.delete();
`ifdef BCH_ENC_PAR_OUT_EN
    exp_cw = '0;
`endif
    #1;
    check_all_zero("midreset");
    repeat (2) cyc(1'b0, 7'h00);
    reset = 1'b1;
    cyc(1'b0, 7'h00);
    encode(7'h01);
    chk15("cw_after_reset", got_cw, 15'h01D1);
    repeat (2) cyc(1'b0, 7'h00);

    // A few random messages
    for (int t = 0; t < 4; t++) begin
      m = 7'($urandom);
      encode(m);
      chk15("cw_random", got_cw, {m, parity_of(m)});
      cyc(1'b0, 7'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bch_15_7_serial_enc.md
BCH_15_7_SERIAL_ENC -- requirements
Module: bch_15_7_serial_enc

Interface
REQ-001 SHALL have parameter GEN_POLY, default 8'hD1, meaning the low 8 coefficients of g(x)=x^8+x^7+x^6+x^4+1 (x^8 implicit).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse marking the first message bit on din.
REQ-005 SHALL have port din  input  1  serial message bit, MSB (m6) first, no gaps.
REQ-006 SHALL have port out_bit  output  1  serial codeword bit, c14 first.
REQ-007 SHALL have port out_valid  output  1  out_bit qualifier.
REQ-008 SHALL have port out_last  output  1  high with the 15th codeword bit (c0).
REQ-009 SHALL have port busy  output  1  high while an encode is in progress.

Function
REQ-010 SHALL implement the FSM states IDLE, MSG and PAR, plus a 4-bit cycle counter.
REQ-011 SHALL, in IDLE with start=1, sample din as m6, clear the LFSR and enter MSG; the start cycle is cycle 0.
REQ-012 SHALL sample din unconditionally in cycles 1..6 as m5..m0; start SHALL be ignored outside IDLE.
REQ-013 SHALL, for each sampled message bit, do fb=din^r[7]; r<={r[6:0],1'b0}^(fb?GEN_POLY:8'h00).
REQ-014 SHALL register each message bit to out_bit with out_valid=1 one cycle after sampling (systematic part, cycles 1..7).
REQ-015 SHALL enter PAR after the 7th bit and output r[7] with r shifting left, zero fill, for 8 cycles (cycles 8..15, p7 first).
REQ-016 SHALL drive out_valid high for exactly cycles 1..15 and out_last high only in cycle 15.
REQ-017 SHALL drive busy high in cycles 1..14 and low in cycle 15 and in IDLE.
REQ-018 SHALL return to IDLE in cycle 15, so a start in cycle 15 begins the next encode back-to-back with no output bubble.
REQ-019 SHALL hold out_bit=0, out_valid=0 and out_last=0 whenever it is not presenting a codeword bit.

Reset
REQ-020 SHALL, while reset=0, immediately force state=IDLE, counter=0, r=8'h00 and out_bit, out_valid, out_last and busy to 0.
REQ-021 SHALL abandon an encode on reset mid-operation: no further out_valid, and the next start after reset release encodes cleanly.

Configuration
REQ-022 SHALL, with macro BCH_ENC_PAR_OUT_EN defined, add outputs cw_out[14:0] (codeword, c14 at MSB) and cw_valid.
REQ-023 SHALL, with BCH_ENC_PAR_OUT_EN defined, pulse cw_valid in cycle 15 and hold cw_out until the next cw_valid or reset; reset value is 0.
REQ-024 SHALL, without the macro, have no cw_out or cw_valid ports and no extra registers; serial behaviour is identical in both builds.

Structure
REQ-025 SHALL take N=15, K=7, PAR_LEN=8, GEN_POLY_DEFAULT and the state enum from shared package bch_15_7_pkg.
REQ-026 SHALL place the 8-bit LFSR divider, with ports for shift, feed-enable, bit-in and remainder, in sub-module bch_lfsr_div.

Verification
REQ-027 SHALL check: message 0000000 -> 15 zero bits in cycles 1..15, out_last in cycle 15.
REQ-028 SHALL check: message 0000001 -> codeword 000000111010001 (parity 8'hD1).
REQ-029 SHALL check: message 1111111 -> codeword of 15 ones (parity 8'hFF).
REQ-030 SHALL check: two starts 15 cycles apart -> 30 consecutive out_valid cycles and two out_last pulses, both codewords correct.
REQ-031 SHALL check: start re-asserted in cycle 5 -> ignored and the first codeword is unchanged.
REQ-032 SHALL check: reset=0 in cycle 9 -> all outputs 0 at once, and a new start with message 0000001 after release yields parity 8'hD1.
